// File: rtl/cmp_pkg.sv
// Shared 2-bit compare result codes and the sequencer state encoding
// used by the sliced magnitude comparator.
package cmp_pkg;

    localparam logic [1:0] CMP_NONE = 2'b00;
    localparam logic [1:0] CMP_EQ   = 2'b01;
    localparam logic [1:0] CMP_GT   = 2'b10;
    localparam logic [1:0] CMP_LT   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/slice_cmp.sv
// Combinational SLICE-bit magnitude compare; top_sgn treats the slice MSB
// as a two's-complement sign bit, otherwise the slice is unsigned.
module slice_cmp
    import cmp_pkg::*;
#(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             top_sgn,
    output logic [1:0]       cmp
);

    // One extra bit lets a single signed compare cover both modes.
    logic signed [SLICE:0] a_ext;
    logic signed [SLICE:0] b_ext;

    assign a_ext = {top_sgn & a[SLICE-1], a};
    assign b_ext = {top_sgn & b[SLICE-1], b};

    always_comb begin
        cmp = CMP_EQ;
        if (a_ext > b_ext) begin
            cmp = CMP_GT;
        end else if (a_ext < b_ext) begin
            cmp = CMP_LT;
        end
    end

endmodule

// File: rtl/compare_seq.sv
// Multi-cycle WIDTH-bit comparator examining SLICE bits per clock, MSB first.
// Define COMPARE_SEQ_EARLY_EXIT_EN to finish on the first differing slice.
module compare_seq
    import cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sgn,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [1:0]       C,
    output logic             busy,
    output logic             done
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NSLICE - 1);
`ifdef COMPARE_SEQ_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q;
    logic               decided_q;
    logic [1:0]         res_q;
    logic [1:0]         c_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic               sgn_q;

    logic [SLICE-1:0]   a_sl, b_sl;
    logic [1:0]         slice_res;
    logic [1:0]         cur_res;
    logic               slice_diff;
    logic               load;
    logic               exit_run;

    assign a_sl = a_q[idx_q*SLICE +: SLICE];
    assign b_sl = b_q[idx_q*SLICE +: SLICE];

    slice_cmp #(.SLICE(SLICE)) u_slice_cmp (
        .a       (a_sl),
        .b       (b_sl),
        .top_sgn (sgn_q && (idx_q == IDX_TOP)),
        .cmp     (slice_res)
    );

    // Once a slice has differed, its verdict is frozen; lower slices are ignored.
    assign slice_diff = (slice_res != CMP_EQ);
    assign cur_res    = decided_q ? res_q : slice_res;

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        exit_run = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if ((idx_q == '0) || (EARLY_EXIT && !decided_q && slice_diff)) begin
                    exit_run = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= IDX_TOP;
            decided_q <= 1'b0;
            c_q       <= CMP_NONE;
        end else begin
            state_q <= state_d;
            if (load) begin
                idx_q     <= IDX_TOP;
                decided_q <= 1'b0;
            end else if (state_q == ST_RUN) begin
                idx_q <= idx_q - IDX_W'(1);
                if (slice_diff) begin
                    decided_q <= 1'b1;
                end
            end
            if (exit_run) begin
                c_q <= cur_res;
            end
        end
    end

    // Operand latches and the frozen verdict are only read after being written.
    always_ff @(posedge clk) begin
        if (load) begin
            a_q   <= A;
            b_q   <= B;
            sgn_q <= sgn;
        end
        if ((state_q == ST_RUN) && !decided_q) begin
            res_q <= slice_res;
        end
    end

    assign C    = c_q;
    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_compare_seq.sv
// Directed bench for compare_seq (WIDTH=16, SLICE=4); latency expectations
// follow COMPARE_SEQ_EARLY_EXIT_EN when it is defined.
module tb_compare_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sgn = 1'b0;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic [1:0]  C;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    compare_seq #(.WIDTH(16), .SLICE(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sgn   (sgn),
        .A     (A),
        .B     (B),
        .C     (C),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [1:0]  c;
        int          lat_full;
        int          lat_early;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int pick_lat(input int lat_full, input int lat_early);
`ifdef COMPARE_SEQ_EARLY_EXIT_EN
        return lat_early;
`else
        return lat_full;
`endif
    endfunction

    // Called 1 time unit after an edge; drives the request and returns
    // with the bench sitting in the done cycle (or after a timeout).
    task automatic do_req(input logic [15:0] a, input logic [15:0] b, input logic s,
                          output logic [1:0] c_out, output int lat,
                          output logic first_busy, output logic busy_ok);
        A = a; B = b; sgn = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        A = ~a; B = ~b; sgn = ~s;
        lat = 1;
        first_busy = busy;
        busy_ok = 1'b1;
        while (!done && lat < 20) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (busy) busy_ok = 1'b0;
        c_out = C;
    endtask

    initial begin
        logic [1:0] c_got;
        int         lat;
        logic       fb, bok;
        logic       saw_done;

        vecs[0] = '{16'h1234, 16'h1234, 1'b0, 2'b01, 5, 5};
        vecs[1] = '{16'h8000, 16'h0001, 1'b1, 2'b11, 5, 2};
        vecs[2] = '{16'h8000, 16'h0001, 1'b0, 2'b10, 5, 2};
        vecs[3] = '{16'h00A5, 16'h00A4, 1'b0, 2'b10, 5, 5};
        vecs[4] = '{16'h00A5, 16'h00A4, 1'b1, 2'b10, 5, 5};
        vecs[5] = '{16'hFFF0, 16'hFFFE, 1'b1, 2'b11, 5, 5};
        vecs[6] = '{16'h0000, 16'hFFFF, 1'b1, 2'b10, 5, 2};
        vecs[7] = '{16'h7FFF, 16'h8000, 1'b0, 2'b11, 5, 2};
        vecs[8] = '{16'h1200, 16'h1300, 1'b0, 2'b11, 5, 3};
        vecs[9] = '{16'h1000, 16'h1000, 1'b1, 2'b01, 5, 5};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_C", C, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_C", C, 0);

        // Table of single requests
        foreach (vecs[i]) begin
            do_req(vecs[i].a, vecs[i].b, vecs[i].s, c_got, lat, fb, bok);
            check($sformatf("vec%0d_C", i), c_got, vecs[i].c);
            check($sformatf("vec%0d_lat", i), lat, pick_lat(vecs[i].lat_full, vecs[i].lat_early));
            check($sformatf("vec%0d_busy_start", i), fb, 1);
            check($sformatf("vec%0d_busy_window", i), bok, 1);
            @(posedge clk); #1;
            check($sformatf("vec%0d_done_pulse", i), done, 0);
            check($sformatf("vec%0d_C_hold", i), C, vecs[i].c);
        end

        // start while busy is ignored
        A = 16'h1234; B = 16'h1234; sgn = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        @(posedge clk); #1;
        lat++;
        A = 16'h8000; B = 16'h0001; sgn = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        lat++;
        start = 1'b0;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("ignore_C", C, 1);
        check("ignore_lat", lat, 5);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("ignore_no_queue", busy, 0);

        // Back-to-back: second start issued in the DONE cycle
        do_req(16'h00A5, 16'h00A4, 1'b0, c_got, lat, fb, bok);
        check("b2b_first_C", c_got, 2);
        do_req(16'h0000, 16'hFFFF, 1'b0, c_got, lat, fb, bok);
        check("b2b_busy_rise", fb, 1);
        check("b2b_second_C", c_got, 3);
        check("b2b_second_lat", lat, pick_lat(5, 2));

        // Reset asserted in the 2nd RUN cycle
        @(posedge clk); #1;
        A = 16'h1234; B = 16'h1234; sgn = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("midrst_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        check("midrst_C", C, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done || busy) saw_done = 1'b1;
        end
        check("midrst_no_done", saw_done, 0);
        do_req(16'h8000, 16'h0001, 1'b0, c_got, lat, fb, bok);
        check("after_rst_C", c_got, 2);
        check("after_rst_lat", lat, pick_lat(5, 2));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
